cs_scan_ctrl: RTL and testbench

Channel scan sequencer for the two-bank 16-channel analog front end. Walks a channel mask, drives the 5-bit `cfg` word into the chip-select decoder, and waits a programmable settle time. It then issues a sample request to the ADC capture block and holds until acknowledge. Between channels it inserts a break-before-make gap with both banks disabled.

---
 rtl/cs_scan_pkg.sv | 27 ++
 rtl/cs_scan_pick.sv | 25 ++
 rtl/cs_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_cs_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_scan_pkg.sv
// Shared encodings for the channel scan sequencer: FSM states, cfg word layout
// and the helper that packs a channel number into an enabled cfg word.
package cs_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_SETTLE,
    ST_SAMPLE,
    ST_GAP
  } state_t;

  localparam logic [4:0] CFG_OFF  = 5'b00000;
  localparam int         CFG_EN   = 4;
  localparam int         CFG_BANK = 3;
  localparam int         NCH      = 16;

  function automatic logic [4:0] cfg_word(input logic [3:0] ch);
    logic [4:0] w;
    w           = CFG_OFF;
    w[CFG_EN]   = 1'b1;
    w[CFG_BANK] = ch[3];
    w[2:0]      = ch[2:0];
    return w;
  endfunction

endpackage

// File: rtl/cs_scan_pick.sv
// Next-channel encoder: lowest set mask bit strictly above the cursor, or the
// lowest set bit overall when the cursor sits "before channel 0".
module cs_scan_pick
  import cs_scan_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [3:0]     cursor,
  input  logic           first,
  output logic           found,
  output logic [3:0]     ch
);

  always_comb begin
    found = 1'b0;
    ch    = 4'd0;
    // Walk downward so the lowest qualifying index is the one that sticks.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cursor)))) begin
        found = 1'b1;
        ch    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/cs_scan_ctrl.sv
// Channel scan sequencer: walks the latched mask, settles each channel, requests
// a sample, and inserts a disabled gap before moving to the next channel.
module cs_scan_ctrl
  import cs_scan_pkg::*;
#(
  parameter int SETTLE_W = 16,
  parameter int GAP_W    = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [GAP_W-1:0]    gap,
  output logic [4:0]          cfg,
  output logic                smp_req,
  input  logic                smp_ack,
  output logic [3:0]          ch_id,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frame_cnt
);

  state_t              state;
  logic [NCH-1:0]      mask_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [GAP_W-1:0]    gap_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic [3:0]          cursor;
  logic                first;
  logic                pk_found;
  logic [3:0]          pk_ch;

  cs_scan_pick u_pick (
    .mask   (mask_q),
    .cursor (cursor),
    .first  (first),
    .found  (pk_found),
    .ch     (pk_ch)
  );

  // A programmed settle of zero still spends one cycle in SETTLE.
  function automatic logic [SETTLE_W-1:0] settle_eff(input logic [SETTLE_W-1:0] s);
    return (s == '0) ? SETTLE_W'(1) : s;
  endfunction

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      cfg        <= CFG_OFF;
      smp_req    <= 1'b0;
      ch_id      <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= 16'd0;
      mask_q     <= '0;
      settle_q   <= '0;
      settle_cnt <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      cursor     <= 4'd0;
      first      <= 1'b1;
    end else if (stop) begin
      state   <= ST_IDLE;
      cfg     <= CFG_OFF;
      smp_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q   <= ch_mask;
            settle_q <= settle;
            gap_q    <= gap;
            first    <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (pk_found) begin
            cursor     <= pk_ch;
            first      <= 1'b0;
            ch_id      <= pk_ch;
            settle_cnt <= settle_eff(settle_q);
            cfg        <= cfg_word(pk_ch);
            state      <= ST_SETTLE;
          end else begin
            // Frame end: a wrap spends one more SEEK cycle with a fresh mask.
            frame_cnt <= frame_cnt + 16'd1;
            if (continuous) begin
              mask_q <= ch_mask;
              first  <= 1'b1;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_W'(1)) begin
            smp_req <= 1'b1;
            state   <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (smp_ack) begin
            smp_req <= 1'b0;
            cfg     <= CFG_OFF;
            if (gap_q != '0) begin
              gap_cnt <= gap_q;
              state   <= ST_GAP;
            end else begin
              state <= ST_SEEK;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            state <= ST_SEEK;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          cfg     <= CFG_OFF;
          smp_req <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_scan_ctrl.sv
// Scoreboarded bench for cs_scan_ctrl: expected channel visits are queued as
// frames are launched and compared when the monitor sees each visit complete.
module tb_cs_scan_ctrl;

  localparam int SETTLE_W = 16;
  localparam int GAP_W    = 8;

  logic                aclk = 1'b0;
  logic                areset = 1'b1;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                continuous = 1'b0;
  logic [15:0]         ch_mask = '0;
  logic [SETTLE_W-1:0] settle = '0;
  logic [GAP_W-1:0]    gap = '0;
  logic [4:0]          cfg;
  logic                smp_req;
  logic                smp_ack;
  logic [3:0]          ch_id;
  logic                busy;
  logic                done;
  logic [15:0]         frame_cnt;

  logic ack_auto = 1'b0;
  logic ack_man  = 1'b0;
  logic ack_en   = 1'b1;
  int   ack_delay = 0;
  assign smp_ack = ack_auto | ack_man;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int ch;
    int nset;
    int nreq;
    int noff;
  } visit_t;
  visit_t exp_q[$];

  always #5 aclk = ~aclk;

  cs_scan_ctrl #(.SETTLE_W(SETTLE_W), .GAP_W(GAP_W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .settle     (settle),
    .gap        (gap),
    .cfg        (cfg),
    .smp_req    (smp_req),
    .smp_ack    (smp_ack),
    .ch_id      (ch_id),
    .busy       (busy),
    .done       (done),
    .frame_cnt  (frame_cnt)
  );

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Visit monitor state
  int         n_set = 0, n_req = 0, n_off = 0, off_before = 0;
  logic       in_visit = 1'b0, cfg_changed = 1'b0;
  logic [4:0] vis_cfg = '0;
  logic [3:0] vis_ch = '0;

  task automatic end_visit();
    visit_t e;
    chk_eq("visit_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_eq("visit_ch", vis_ch, e.ch);
      chk_eq("visit_cfg", vis_cfg, 5'h10 | e.ch);
      chk_eq("visit_cfg_stable", cfg_changed, 0);
      if (e.nset >= 0) chk_eq("visit_settle_cycles", n_set, e.nset);
      if (e.nreq >= 0) chk_eq("visit_req_cycles", n_req, e.nreq);
      if (e.noff >= 0) chk_eq("visit_off_before", off_before, e.noff);
    end
  endtask

  always @(negedge aclk) begin
    ack_auto = 1'b0;
    if (done) chk_eq("busy_at_done", busy, 0);
    if (smp_req) chk_eq("req_only_when_enabled", cfg[4], 1);
    if (cfg[4]) begin
      if (!in_visit) begin
        in_visit    = 1'b1;
        vis_cfg     = cfg;
        vis_ch      = ch_id;
        n_set       = 0;
        n_req       = 0;
        cfg_changed = 1'b0;
        off_before  = n_off;
      end
      if (cfg !== vis_cfg) cfg_changed = 1'b1;
      if (smp_req) begin
        n_req++;
        if (ack_en && n_req == ack_delay + 1) ack_auto = 1'b1;
      end else if (n_req == 0) begin
        n_set++;
      end
    end else begin
      if (in_visit) begin
        end_visit();
        in_visit = 1'b0;
        n_off    = 0;
      end
      n_off++;
    end
  end

  task automatic push_visit(input int ch, input int nset, input int nreq, input int noff);
    visit_t v;
    v.ch = ch; v.nset = nset; v.nreq = nreq; v.noff = noff;
    exp_q.push_back(v);
  endtask

  task automatic pulse_start(input logic [15:0] m, input int s, input int g);
    ch_mask = m;
    settle  = SETTLE_W'(s);
    gap     = GAP_W'(g);
    start   = 1'b1;
    @(negedge aclk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge aclk);
      n++;
    end
    chk_eq(tag, done, 1);
  endtask

  initial begin
    int n;
    int base;
    int prev;

    // Reset state
    repeat (3) @(negedge aclk);
    chk_eq("rst_cfg", cfg, 0);
    chk_eq("rst_req", smp_req, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_frame_cnt", frame_cnt, 0);
    chk_eq("rst_ch_id", ch_id, 0);
    areset = 1'b0;
    @(negedge aclk);

    // Two channels, settle 3, gap 2, immediate ack
    ack_delay = 0;
    push_visit(0, 3, 1, -1);
    push_visit(3, 3, 1, 3);
    pulse_start(16'h0009, 3, 2);
    chk_eq("t1_busy_in_seek", busy, 1);
    n = 0;
    while (!cfg[4] && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk_eq("t1_first_cfg_latency", n, 1);
    wait_done("t1_done_seen", 100, n);
    @(negedge aclk);
    chk_eq("t1_done_one_cycle", done, 0);
    chk_eq("t1_frame_cnt", frame_cnt, 1);
    chk_eq("t1_queue_drained", exp_q.size(), 0);

    // ch0 and ch15, gap 0, ack delayed 5 cycles, mask changed mid-frame
    ack_delay = 5;
    push_visit(0, 2, 6, -1);
    push_visit(15, 2, 6, 1);
    pulse_start(16'h8001, 2, 0);
    ch_mask = 16'h00F0;
    wait_done("t2_done_seen", 200, n);
    @(negedge aclk);
    chk_eq("t2_frame_cnt", frame_cnt, 2);
    chk_eq("t2_queue_drained", exp_q.size(), 0);
    ack_delay = 0;

    // Empty mask
    pulse_start(16'h0000, 3, 2);
    wait_done("t3_done_seen", 20, n);
    chk_eq("t3_done_latency", n, 1);
    @(negedge aclk);
    chk_eq("t3_frame_cnt", frame_cnt, 3);
    chk_eq("t3_busy_after", busy, 0);

    // Continuous rescans of ch8, then drop continuous for a final frame
    continuous = 1'b1;
    base = int'(frame_cnt);
    for (int i = 0; i < 4; i++) push_visit(8, 1, 1, (i == 0) ? -1 : 3);
    pulse_start(16'h0100, 1, 1);
    prev = base;
    for (int f = 1; f <= 3; f++) begin
      n = 0;
      while (int'(frame_cnt) == prev && n < 100) begin
        @(negedge aclk);
        n++;
        if (done) chk_eq("t4_no_done_while_cont", done, 0);
      end
      chk_eq("t4_frame_cnt_step", frame_cnt, base + f);
      chk_eq("t4_busy_on_wrap", busy, 1);
      prev = int'(frame_cnt);
    end
    continuous = 1'b0;
    wait_done("t4_done_seen", 100, n);
    chk_eq("t4_frame_cnt_final", frame_cnt, base + 4);
    @(negedge aclk);
    chk_eq("t4_queue_drained", exp_q.size(), 0);

    // Stop during SAMPLE with a late ack
    ack_en = 1'b0;
    base = int'(frame_cnt);
    push_visit(1, 2, -1, -1);
    pulse_start(16'h0002, 2, 0);
    n = 0;
    while (!smp_req && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk_eq("t5_reached_sample", smp_req, 1);
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    chk_eq("t5_stop_busy", busy, 0);
    chk_eq("t5_stop_cfg", cfg, 0);
    chk_eq("t5_stop_req", smp_req, 0);
    chk_eq("t5_stop_done", done, 0);
    @(negedge aclk);
    ack_man = 1'b1;
    @(negedge aclk);
    ack_man = 1'b0;
    chk_eq("t5_late_ack_busy", busy, 0);
    chk_eq("t5_late_ack_req", smp_req, 0);
    chk_eq("t5_late_ack_done", done, 0);
    chk_eq("t5_frame_cnt_kept", frame_cnt, base);
    ch_mask = 16'h0004;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    stop  = 1'b0;
    chk_eq("t5_start_stop_busy", busy, 0);
    chk_eq("t5_start_stop_cfg", cfg, 0);
    @(negedge aclk);
    chk_eq("t5_start_stop_idle", busy, 0);
    chk_eq("t5_queue_drained", exp_q.size(), 0);
    ack_en = 1'b1;

    // Reset mid-SETTLE, then a clean frame with settle 0
    push_visit(4, -1, -1, -1);
    pulse_start(16'h0010, 10, 0);
    n = 0;
    while (!cfg[4] && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk_eq("t6_reached_settle", cfg[4], 1);
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk_eq("t6_rst_cfg", cfg, 0);
    chk_eq("t6_rst_req", smp_req, 0);
    chk_eq("t6_rst_ch_id", ch_id, 0);
    chk_eq("t6_rst_busy", busy, 0);
    chk_eq("t6_rst_done", done, 0);
    chk_eq("t6_rst_frame_cnt", frame_cnt, 0);
    @(negedge aclk);
    push_visit(5, 1, 1, -1);
    pulse_start(16'h0020, 0, 1);
    wait_done("t6_done_seen", 100, n);
    chk_eq("t6_frame_cnt", frame_cnt, 1);
    @(negedge aclk);
    chk_eq("t6_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
